// File: rtl/dcache_ctrl_if.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_if
// Word-wide main-memory handshake between the data cache controller (master)
// and main memory (slave). A beat is in flight while mem_req=1 and completes
// on the rising clock edge where mem_ready=1.
//   mem_req    master->slave  request valid
//   mem_we     master->slave  1 write, 0 read
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  write data, store lanes replicated
//   mem_wstrb  master->slave  byte-lane enables
//   mem_rdata  slave->master  read data, valid with mem_ready
//   mem_ready  slave->master  completes the current beat
// -----------------------------------------------------------------------------
interface dcache_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller
// sitting between a single-cycle core's data port and word-wide main memory.
//   clk, rst_n          clock, asynchronous active-low reset
//   MemRead, MemWrite   core access strobes (write wins when both are set)
//   Addr                byte address, held by the core while Stall=1
//   WriteData           right-aligned store data
//   Storetype           00 byte, 01 half, 10/11 word
//   ReadData            aligned 32-bit word at Addr[31:2]
//   Stall               core must hold PC/state
//   bus                 memory handshake (dcache_ctrl_if.master)
// Read misses refill the whole line, one word per beat, then the retried
// access hits. Stores always go through to memory; a store that hits also
// updates the cached word, a store that misses leaves the cache untouched.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int NUM_LINES      = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [31:0]   Addr,
    input  logic [31:0]   WriteData,
    input  logic [1:0]    Storetype,
    output logic [31:0]   ReadData,
    output logic          Stall,
    dcache_ctrl_if.master bus
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic [OFF_W-1:0] addr_off;
    logic             hit;
    logic [3:0]       st_wstrb;
    logic [31:0]      st_wdata;
    logic             fill_start;
    logic             fill_beat;
    logic             fill_last;
    logic             write_done;

    assign addr_tag = Addr[31 -: TAG_W];
    assign addr_idx = Addr[2 + OFF_W +: IDX_W];
    assign addr_off = Addr[2 +: OFF_W];
    assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign ReadData = data_q[addr_idx][addr_off];

    // Store lane placement; misaligned low address bits fall out of the shifts.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = WriteData;
        unique case (Storetype)
            2'b00: begin
                st_wstrb = 4'b0001 << Addr[1:0];
                st_wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << {Addr[1], 1'b0};
                st_wdata = {2{WriteData[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = WriteData;
            end
        endcase
    end

    // Bus outputs are decoded from state so an asynchronous reset drops the
    // request the same instant it forces IDLE.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        Stall         = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        fill_start    = 1'b0;
        fill_beat     = 1'b0;
        fill_last     = 1'b0;
        write_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    state_d = WRITE;
                    Stall   = 1'b1;
                end else if (MemRead && !hit) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    Stall      = 1'b1;
                    fill_start = 1'b1;
                end
            end
            FILL: begin
                Stall        = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_tag, addr_idx, cnt_q, 2'b00};
                if (bus.mem_ready) begin
                    fill_beat = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WRITE: begin
                // The core advances on the same edge the write completes.
                Stall         = !bus.mem_ready;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {Addr[31:2], 2'b00};
                bus.mem_wdata = st_wdata;
                bus.mem_wstrb = st_wstrb;
                if (bus.mem_ready) begin
                    write_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // The line is invalid while being refilled, so an interrupted
            // refill can never expose a half-old, half-new line.
            if (fill_start) valid_q[addr_idx] <= 1'b0;
            if (fill_last)  valid_q[addr_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; valid_q alone decides whether
    // their contents mean anything, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_q[addr_idx][cnt_q] <= bus.mem_rdata;
        end
        if (fill_last) begin
            tag_q[addr_idx] <= addr_tag;
        end
        if (write_done && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (st_wstrb[b]) data_q[addr_idx][addr_off][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
    end

endmodule
